// File: rtl/pwm_ramp_pkg.sv
// Shared types and widths for the PWM duty ramp sequencer.
package pwm_ramp_pkg;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned RATE_W = 8;
  localparam int unsigned ACC_W  = DUTY_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD      = 2'd3
  } ramp_state_e;

  typedef struct packed {
    logic [DUTY_W-1:0] target;
    logic [STEP_W-1:0] step;
    logic [RATE_W-1:0] rate;
  } ramp_cfg_t;

  // A zero step would stall the ramp forever, so it is promoted to one.
  function automatic logic [STEP_W-1:0] eff_step(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction

endpackage

// File: rtl/pwm_ramp_prescaler.sv
// Tick generator: counts 0..rate and emits a one-cycle tick on the last count.
module pwm_ramp_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] rate,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_q, count_d;

  // Next count; disabled parks at zero, clear restarts the interval and drops the tick.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (!enable || clear) begin
      count_d = '0;
    end else if (count_q == rate) begin
      tick    = 1'b1;
      count_d = '0;
    end else begin
      count_d = count_q + PRESCALE_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Ramps the PWM duty toward a configured target, one step per prescaler tick.
// Optional sticky done interrupt: define PWM_RAMP_IRQ_EN.
module pwm_ramp_sequencer
  import pwm_ramp_pkg::*;
#(
  parameter int unsigned       PRESCALE_W = 16,
  parameter logic [DUTY_W-1:0] RESET_DUTY = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  input  logic [DUTY_W-1:0] cfg_target,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [RATE_W-1:0] cfg_rate,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
`ifdef PWM_RAMP_IRQ_EN
  ,
  input  logic              irq_clr,
  output logic              irq
`endif
);

  ramp_state_e       state_q, state_d;
  ramp_cfg_t         cfg_q, cfg_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pending_q, pending_d;
  logic              done_q, done_d;
  logic              tick;
  logic [DUTY_W-1:0] eval_target;
  logic [ACC_W-1:0]  diff_up, diff_dn, step_acc;

  // A config that arrived while disabled is evaluated on the first enabled cycle.
  assign eval_target = cfg_valid ? cfg_target : cfg_q.target;
  assign diff_up     = ACC_W'(cfg_q.target) - ACC_W'(duty_q);
  assign diff_dn     = ACC_W'(duty_q) - ACC_W'(cfg_q.target);
  assign step_acc    = ACC_W'(cfg_q.step);

  pwm_ramp_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (cfg_valid | pending_q),
    .rate   (PRESCALE_W'(cfg_q.rate)),
    .tick   (tick)
  );

  // Next-state, duty and done; new config beats a same-cycle tick.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    duty_d    = duty_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (cfg_valid) begin
      cfg_d.target = cfg_target;
      cfg_d.step   = eff_step(cfg_step);
      cfg_d.rate   = cfg_rate;
    end
    if (enable) begin
      if (cfg_valid || pending_q) begin
        pending_d = 1'b0;
        if (eval_target > duty_q) begin
          state_d = RAMP_UP;
        end else if (eval_target < duty_q) begin
          state_d = RAMP_DOWN;
        end else begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
      end else if (tick) begin
        unique case (state_q)
          RAMP_UP: begin
            if (diff_up <= step_acc) begin
              duty_d  = cfg_q.target;
              state_d = HOLD;
              done_d  = 1'b1;
            end else begin
              duty_d = DUTY_W'(ACC_W'(duty_q) + step_acc);
            end
          end
          RAMP_DOWN: begin
            if (diff_dn <= step_acc) begin
              duty_d  = cfg_q.target;
              state_d = HOLD;
              done_d  = 1'b1;
            end else begin
              duty_d = DUTY_W'(ACC_W'(duty_q) - step_acc);
            end
          end
          default: ;
        endcase
      end
    end else if (cfg_valid) begin
      pending_d = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q     <= '{target: RESET_DUTY, step: STEP_W'(1), rate: '0};
      duty_q    <= RESET_DUTY;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      duty_q    <= duty_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign duty_out = duty_q;
  assign done     = done_q;
  assign busy     = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

`ifdef PWM_RAMP_IRQ_EN
  logic irq_q, irq_d;

  // Sticky flag: a done pulse overrides a same-cycle clear.
  always_comb begin
    irq_d = done_q | (irq_q & ~irq_clr);
  end

  // Interrupt flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer: stimulus queues expected duty/done events,
// a negedge monitor pops and compares each one as the DUT presents it.
module tb_pwm_ramp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_target = '0;
  logic [3:0] cfg_step = '0;
  logic [7:0] cfg_rate = '0;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;
`ifdef PWM_RAMP_IRQ_EN
  logic       irq_clr = 1'b0;
  logic       irq;
`endif

  pwm_ramp_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_target (cfg_target),
    .cfg_step   (cfg_step),
    .cfg_rate   (cfg_rate),
    .duty_out   (duty_out),
    .busy       (busy),
    .done       (done)
`ifdef PWM_RAMP_IRQ_EN
    ,
    .irq_clr    (irq_clr),
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] duty;
    logic       done;
    logic       busy;
    int         gap;   // cycles since previous event, -1 = not checked
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [7:0] prev_duty = '0;

  // Monitor: any duty change or done pulse is an event matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_en && rst_n && (duty_out !== prev_duty || done === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event duty=%0d done=%0b busy=%0b at cycle %0d",
                 duty_out, done, busy, cyc);
      end else begin
        e = exp_q.pop_front();
        if (duty_out !== e.duty || done !== e.done || busy !== e.busy ||
            (e.gap >= 0 && (cyc - last_cyc) != e.gap)) begin
          errors++;
          $display("FAIL event got duty=%0d done=%0b busy=%0b gap=%0d, expected duty=%0d done=%0b busy=%0b gap=%0d",
                   duty_out, done, busy, cyc - last_cyc, e.duty, e.done, e.busy, e.gap);
        end
      end
      last_cyc = cyc;
    end
    prev_duty = duty_out;
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic dn, input logic b, input int g);
    exp_t e;
    e.duty = d;
    e.done = dn;
    e.busy = b;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  // Drives a one-cycle cfg strobe in the current cycle.
  task automatic cfg(input logic [7:0] t, input logic [3:0] s, input logic [7:0] r);
    cfg_valid  = 1'b1;
    cfg_target = t;
    cfg_step   = s;
    cfg_rate   = r;
    step_cyc();
    cfg_valid  = 1'b0;
  endtask

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  // Waits (bounded) for all queued events, then a few quiet cycles to catch extras.
  task automatic drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) step_cyc();
    repeat (3) step_cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d events pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_duty(input logic [7:0] v, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (duty_out == v) break;
      step_cyc();
    end
    check("wait_duty", int'(duty_out), int'(v));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) step_cyc();
    rst_n  = 1'b1;
    step_cyc();
    mon_en = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) step_cyc();
    check("reset_duty", int'(duty_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    step_cyc();
    mon_en = 1'b1;
    enable = 1'b1;

    // Up-ramp 0 -> 20, step 5, rate 3
    push(8'd5, 0, 1, -1); push(8'd10, 0, 1, 4); push(8'd15, 0, 1, 4); push(8'd20, 1, 0, 4);
    cfg(8'd20, 4'd5, 8'd3);
    drain("up_ramp", 100);
    check("up_hold_duty", int'(duty_out), 20);
    check("up_hold_busy", int'(busy), 0);

    // Down-ramp with clamp at target 3
    push(8'd12, 0, 1, -1); push(8'd4, 0, 1, 1); push(8'd3, 1, 0, 1);
    cfg(8'd3, 4'd8, 8'd0);
    drain("down_clamp", 50);

    // Retarget mid-ramp at 50
    do_reset();
    for (int v = 1; v <= 50; v++) push(8'(v), 0, 1, (v == 1) ? -1 : 1);
    push(8'd49, 0, 1, 2);
    for (int v = 48; v >= 11; v--) push(8'(v), 0, 1, 1);
    push(8'd10, 1, 0, 1);
    cfg(8'd200, 4'd1, 8'd0);
    wait_duty(8'd50, 200);
    cfg(8'd10, 4'd1, 8'd0);
    drain("retarget", 200);

    // Freeze at 40 for 30 cycles, rate 2
    do_reset();
    for (int v = 2; v <= 40; v += 2) push(8'(v), 0, 1, (v == 2) ? -1 : 3);
    push(8'd42, 0, 1, 33);
    for (int v = 44; v <= 98; v += 2) push(8'(v), 0, 1, 3);
    push(8'd100, 1, 0, 3);
    cfg(8'd100, 4'd2, 8'd2);
    wait_duty(8'd40, 300);
    enable = 1'b0;
    repeat (15) step_cyc();
    check("freeze_mid_duty", int'(duty_out), 40);
    repeat (15) step_cyc();
    check("freeze_duty", int'(duty_out), 40);
    check("freeze_busy", int'(busy), 1);
    enable = 1'b1;
    drain("freeze", 400);

    // Async reset between edges at 77
    do_reset();
    for (int v = 1; v <= 76; v++) push(8'(v), 0, 1, (v == 1) ? -1 : 1);
    cfg(8'd200, 4'd1, 8'd0);
    wait_duty(8'd77, 200);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_duty", int'(duty_out), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_events", exp_q.size(), 0);
    exp_q.delete();
    step_cyc();
    rst_n = 1'b1;
    step_cyc();
    mon_en = 1'b1;

    // Step 0 acts as 1, then an equal target gives done next cycle
    push(8'd1, 0, 1, -1); push(8'd2, 0, 1, 1); push(8'd3, 1, 0, 1);
    cfg(8'd3, 4'd0, 8'd0);
    drain("step_zero", 50);
    push(8'd3, 1, 0, -1);
    cfg(8'd3, 4'd5, 8'd4);
    check("equal_done_next", int'(done), 1);
    check("equal_duty", int'(duty_out), 3);
    drain("equal_target", 20);
`ifdef PWM_RAMP_IRQ_EN
    check("irq_set", int'(irq), 1);
    repeat (5) step_cyc();
    check("irq_sticky", int'(irq), 1);
    irq_clr = 1'b1;
    step_cyc();
    irq_clr = 1'b0;
    check("irq_cleared", int'(irq), 0);
`endif

    // Config while disabled is deferred until enable rises
    enable = 1'b0;
    cfg(8'd0, 4'd1, 8'd0);
    repeat (5) step_cyc();
    check("deferred_duty", int'(duty_out), 3);
    check("deferred_busy", int'(busy), 0);
    push(8'd2, 0, 1, -1); push(8'd1, 0, 1, 1); push(8'd0, 1, 0, 1);
    enable = 1'b1;
    drain("deferred", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
